// File: rtl/seq_ctrl.sv
// Multi-cycle sequencer for the sequential Y86-64 core: owns the PC, walks the
// datapath through one stage per cycle, and tracks status and retired count.
module seq_ctrl #(
    parameter logic [63:0] RESET_PC = 64'd0,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stall,
    input  logic [3:0]       icode,
    input  logic             imem_error,
    input  logic             instr_valid,
    input  logic             cnd,
    input  logic             dmem_error,
    input  logic [63:0]      valC,
    input  logic [63:0]      valP,
    input  logic [63:0]      valM,
    output logic [63:0]      pc,
    output logic             f_en,
    output logic             d_en,
    output logic             e_en,
    output logic             m_en,
    output logic             w_en,
    output logic [2:0]       stat,
    output logic             busy,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        StIdle, StFetch, StDecode, StExecute, StMemory, StWriteback, StPcupd, StHalted
    } state_e;

    localparam logic [2:0] StatAok = 3'd1;
    localparam logic [2:0] StatHlt = 3'd2;
    localparam logic [2:0] StatAdr = 3'd3;
    localparam logic [2:0] StatIns = 3'd4;

    localparam logic [3:0] IcodeHalt = 4'h0;
    localparam logic [3:0] IcodeJxx  = 4'h7;
    localparam logic [3:0] IcodeCall = 4'h8;
    localparam logic [3:0] IcodeRet  = 4'h9;

    state_e           state_q, state_d;
    logic [63:0]      pc_q, pc_d;
    logic [2:0]       stat_q, stat_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic [3:0]       icode_q, icode_d;
    logic [63:0]      valc_q, valc_d;
    logic [63:0]      valp_q, valp_d;
    logic [63:0]      valm_q, valm_d;
    logic             cnd_q, cnd_d;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        stat_d    = stat_q;
        retired_d = retired_q;
        icode_d   = icode_q;
        valc_d    = valc_q;
        valp_d    = valp_q;
        valm_d    = valm_q;
        cnd_d     = cnd_q;

        // A stalled cycle freezes everything, including error sampling.
        if (!stall) begin
            unique case (state_q)
                StIdle: begin
                    if (start) state_d = StFetch;
                end
                StFetch: begin
                    if (imem_error) begin
                        stat_d  = StatAdr;
                        state_d = StHalted;
                    end else if (!instr_valid) begin
                        stat_d  = StatIns;
                        state_d = StHalted;
                    end else if (icode == IcodeHalt) begin
                        stat_d  = StatHlt;
                        state_d = StHalted;
                    end else begin
                        icode_d = icode;
                        valc_d  = valC;
                        valp_d  = valP;
                        state_d = StDecode;
                    end
                end
                StDecode: state_d = StExecute;
                StExecute: begin
                    cnd_d   = cnd;
                    state_d = StMemory;
                end
                StMemory: begin
                    valm_d = valM;
                    if (dmem_error) begin
                        stat_d  = StatAdr;
                        state_d = StHalted;
                    end else begin
                        state_d = StWriteback;
                    end
                end
                StWriteback: state_d = StPcupd;
                StPcupd: begin
                    if (icode_q == IcodeCall || (icode_q == IcodeJxx && cnd_q)) begin
                        pc_d = valc_q;
                    end else if (icode_q == IcodeRet) begin
                        pc_d = valm_q;
                    end else begin
                        pc_d = valp_q;
                    end
                    retired_d = retired_q + CNT_W'(1);
                    state_d   = StFetch;
                end
                StHalted: state_d = StHalted;
                default:  state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            pc_q      <= RESET_PC;
            stat_q    <= StatAok;
            retired_q <= '0;
            icode_q   <= '0;
            valc_q    <= '0;
            valp_q    <= '0;
            valm_q    <= '0;
            cnd_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            stat_q    <= stat_d;
            retired_q <= retired_d;
            icode_q   <= icode_d;
            valc_q    <= valc_d;
            valp_q    <= valp_d;
            valm_q    <= valm_d;
            cnd_q     <= cnd_d;
        end
    end

    always_comb begin
        f_en   = (state_q == StFetch);
        d_en   = (state_q == StDecode);
        e_en   = (state_q == StExecute);
        m_en   = (state_q == StMemory);
        w_en   = (state_q == StWriteback);
        busy   = (state_q != StIdle) && (state_q != StHalted);
        halted = (state_q == StHalted);
    end

    assign pc      = pc_q;
    assign stat    = stat_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_seq_ctrl.sv
// Directed bench for seq_ctrl: a table of instructions walked through all stages,
// then hand-written halt, fault, stall and reset sequences.
module tb_seq_ctrl;

    localparam logic [63:0] RST_PC = 64'd32;

    logic        clk = 1'b0;
    logic        rst_n, start, stall, imem_error, instr_valid, cnd, dmem_error;
    logic [3:0]  icode;
    logic [63:0] valC, valP, valM, pc;
    logic        f_en, d_en, e_en, m_en, w_en, busy, halted;
    logic [2:0]  stat;
    logic [31:0] retired;
    logic [4:0]  en;

    int checks = 0;
    int errors = 0;

    seq_ctrl #(.RESET_PC(RST_PC), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .icode(icode),
        .imem_error(imem_error), .instr_valid(instr_valid), .cnd(cnd),
        .dmem_error(dmem_error), .valC(valC), .valP(valP), .valM(valM), .pc(pc),
        .f_en(f_en), .d_en(d_en), .e_en(e_en), .m_en(m_en), .w_en(w_en),
        .stat(stat), .busy(busy), .halted(halted), .retired(retired)
    );

    always #5 clk = ~clk;
    assign en = {f_en, d_en, e_en, m_en, w_en};

    typedef struct {
        logic [3:0]  icode;
        logic        cnd;
        logic [63:0] valc;
        logic [63:0] valp;
        logic [63:0] valm;
        logic [63:0] exp_pc;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        #1 rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        start = 1'b0; stall = 1'b0; imem_error = 1'b0; instr_valid = 1'b1;
        dmem_error = 1'b0; cnd = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Walks one instruction from FETCH to the next FETCH, checking every stage.
    task automatic run_instr(input vec_t v, input int unsigned exp_ret);
        logic [4:0] exp_en;
        icode = v.icode; cnd = v.cnd; valC = v.valc; valP = v.valp; valM = v.valm;
        for (int k = 0; k < 6; k++) begin
            exp_en = 5'b10000 >> k;
            chk("stage_enables", 64'(en), 64'(exp_en));
            chk("busy_running", 64'(busy), 64'd1);
            tick();
        end
        chk("new_pc", pc, v.exp_pc);
        chk("retired", 64'(retired), 64'(exp_ret));
        chk("next_fetch_en", 64'(en), 64'(5'b10000));
    endtask

    initial begin
        vecs[0] = '{4'h6, 1'b0, 64'h0,   64'd34,  64'h0,  64'd34};
        vecs[1] = '{4'h7, 1'b1, 64'd100, 64'd41,  64'h0,  64'd100};
        vecs[2] = '{4'h7, 1'b0, 64'd100, 64'd41,  64'h0,  64'd41};
        vecs[3] = '{4'h8, 1'b0, 64'h200, 64'h209, 64'h0,  64'h200};
        vecs[4] = '{4'h9, 1'b1, 64'h300, 64'h99,  64'h50, 64'h50};
        vecs[5] = '{4'h2, 1'b1, 64'h777, 64'd38,  64'h0,  64'd38};

        rst_n = 1'b1; start = 1'b0; stall = 1'b0; icode = 4'h0; imem_error = 1'b0;
        instr_valid = 1'b1; cnd = 1'b0; dmem_error = 1'b0;
        valC = '0; valP = '0; valM = '0;

        do_reset();
        chk("reset_pc", pc, RST_PC);
        chk("reset_stat", 64'(stat), 64'd1);
        chk("reset_en", 64'(en), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_halted", 64'(halted), 64'd0);
        chk("reset_retired", 64'(retired), 64'd0);
        tick();
        chk("idle_holds", 64'(en), 64'd0);

        do_start();
        chk("start_pc", pc, RST_PC);
        for (int i = 0; i < 6; i++) run_instr(vecs[i], i + 1);

        // halt at pc=38
        icode = 4'h0;
        tick();
        chk("hlt_stat", 64'(stat), 64'd2);
        chk("hlt_halted", 64'(halted), 64'd1);
        chk("hlt_busy", 64'(busy), 64'd0);
        chk("hlt_en", 64'(en), 64'd0);
        chk("hlt_pc", pc, 64'd38);
        chk("hlt_retired", 64'(retired), 64'd6);
        do_start();
        tick();
        chk("hlt_start_ignored", 64'(halted), 64'd1);
        chk("hlt_start_en", 64'(en), 64'd0);

        // imem_error beats !instr_valid
        do_reset();
        do_start();
        imem_error = 1'b1; instr_valid = 1'b0; icode = 4'h6;
        tick();
        chk("imem_stat", 64'(stat), 64'd3);
        chk("imem_halted", 64'(halted), 64'd1);
        chk("imem_no_decode", 64'(en), 64'd0);
        chk("imem_pc", pc, RST_PC);

        do_reset();
        do_start();
        instr_valid = 1'b0; icode = 4'h6;
        tick();
        chk("ins_stat", 64'(stat), 64'd4);
        chk("ins_halted", 64'(halted), 64'd1);

        // dmem_error in MEMORY skips WRITEBACK
        do_reset();
        do_start();
        icode = 4'h5; valP = 64'd42;
        tick(); tick(); tick();
        chk("dmem_at_mem", 64'(en), 64'(5'b00010));
        dmem_error = 1'b1;
        tick();
        dmem_error = 1'b0;
        chk("dmem_stat", 64'(stat), 64'd3);
        chk("dmem_halted", 64'(halted), 64'd1);
        chk("dmem_no_wb", 64'(w_en), 64'd0);
        chk("dmem_pc", pc, RST_PC);
        chk("dmem_retired", 64'(retired), 64'd0);

        // stall priority in FETCH, stall in EXECUTE, then reset mid-MEMORY
        do_reset();
        do_start();
        run_instr(vecs[0], 1);
        stall = 1'b1; imem_error = 1'b1;
        tick();
        chk("stall_fetch_en", 64'(en), 64'(5'b10000));
        chk("stall_fetch_stat", 64'(stat), 64'd1);
        stall = 1'b0; imem_error = 1'b0;
        icode = 4'h6; valP = 64'd50;
        tick(); tick();
        chk("exec_entry", 64'(e_en), 64'd1);
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_exec_en", 64'(e_en), 64'd1);
            chk("stall_pc", pc, 64'd34);
        end
        stall = 1'b0;
        tick();
        chk("after_stall_mem", 64'(en), 64'(5'b00010));
        chk("after_stall_ret", 64'(retired), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("midreset_en", 64'(en), 64'd0);
        chk("midreset_busy", 64'(busy), 64'd0);
        chk("midreset_pc", pc, RST_PC);
        chk("midreset_stat", 64'(stat), 64'd1);
        chk("midreset_retired", 64'(retired), 64'd0);
        rst_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_ctrl.md
# seq_ctrl

Multi-cycle sequencer for the sequential Y86-64 core. Owns the architectural PC register, steps the datapath through fetch, decode, execute, memory, writeback and PC-update one state per cycle, and emits one-hot stage enables. Samples fetch/memory error flags to produce the processor status code and stop on halt or exception. Counts retired instructions.

## Interface
- RESET_PC, 64'd0, PC value loaded on reset
- CNT_W, 32, width of retired-instruction counter
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin execution; honoured only in IDLE
- stall  in  1  freeze current state and all registers for this cycle
- icode  in  4  instruction code from fetch
- imem_error  in  1  fetch address error
- instr_valid  in  1  fetch decoded a legal icode/ifun
- cnd  in  1  condition result from execute
- dmem_error  in  1  data memory address error
- valC  in  64  constant word from fetch
- valP  in  64  fall-through PC from fetch
- valM  in  64  word read by memory stage
- pc  out  64  current PC, drives fetch
- f_en, d_en, e_en, m_en, w_en  out  1 each  stage enables, one-hot
- stat  out  3  1=AOK, 2=HLT, 3=ADR, 4=INS
- busy  out  1  high in any state except IDLE and HALTED
- halted  out  1  high in HALTED
- retired  out  CNT_W  instructions completed through PCUPD

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, HALTED.
- IDLE -> FETCH when start=1; otherwise hold. start ignored in all other states.
- FETCH -> DECODE -> EXECUTE -> MEMORY -> WRITEBACK -> PCUPD -> FETCH, one state per unstalled cycle.
- Enables: f_en in FETCH, d_en in DECODE, e_en in EXECUTE, m_en in MEMORY, w_en in WRITEBACK; all low in IDLE, PCUPD, HALTED.
- End of FETCH, priority order: imem_error -> stat=ADR, go HALTED; else !instr_valid -> stat=INS, HALTED; else icode==0 -> stat=HLT, HALTED; else latch icode, valC, valP, continue.
- End of EXECUTE: latch cnd. End of MEMORY: latch valM; dmem_error -> stat=ADR, HALTED (WRITEBACK skipped).
- PCUPD new PC: icode 8 (call) -> valC; icode 7 (jXX) and cnd=1 -> valC; icode 9 (ret) -> valM; else valP. retired increments by 1, wraps modulo 2^CNT_W.
- On any halt, pc holds the faulting/halting instruction address; retired does not increment.
- HALTED is terminal; exit only via rst_n.
- stall=1: state, pc, latches, stat, retired hold; enable of current state stays asserted. stall has priority over error sampling (flags sampled only on the unstalled exit cycle).

## Timing
- Reset (async, rst_n=0): state=IDLE, pc=RESET_PC, stat=AOK, all enables 0, busy=0, halted=0, retired=0, internal latches 0. Reset mid-instruction aborts it with no PC update.
- Enables and busy/halted decode from registered state (Moore); no combinational input-to-output path.
- Unstalled instruction latency: 6 cycles FETCH-entry to next FETCH-entry; pc updates at the edge leaving PCUPD, visible in the following FETCH.
- start sampled at rising edge in IDLE; FETCH begins next cycle, f_en high with pc=RESET_PC.
- HLT/INS/ADR from FETCH: stat and halted valid the cycle after FETCH; DECODE never entered.
- ADR from MEMORY: stat/halted valid the cycle after MEMORY.

## Test plan
- Reset then start with RESET_PC=32, icode=6, instr_valid=1, valP=34 -> enables step f,d,e,m,w over 5 cycles, PCUPD, pc=34 in next FETCH, retired=1.
- jXX icode=7, valC=100, valP=41: cnd=1 -> pc=100; repeat cnd=0 -> pc=41.
- call icode=8 valC=0x200 -> pc=0x200; ret icode=9 valM=0x50 -> pc=0x50.
- icode=0 at pc=38 -> stat=2, halted=1, pc=38, retired unchanged; start afterwards ignored.
- imem_error=1 in FETCH -> stat=3, DECODE not entered; dmem_error=1 in MEMORY -> stat=3, w_en never asserted.
- stall held 3 cycles in EXECUTE -> e_en high 4 cycles total, pc/retired unchanged; rst_n low during MEMORY -> immediate IDLE, pc=RESET_PC, stat=1, retired=0.
